// File: rtl/wave_gen.sv
// wave_gen: multi-mode waveform generator (saw up, saw down, triangle, square).
//
// The active configuration (mode, amplitude, prescaler) is held in shadow
// registers that load only on a start event or on a period wrap step. Mid-period
// writes therefore never disturb the current period.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   ena          run enable; low clears the block to idle on the next edge
//   mode         0 saw up, 1 saw down, 2 triangle, 3 square
//   amplitude    peak value A (unsigned)
//   prescaler    P; one step every P+1 clocks
//   data         current sample (registered)
//   data_valid   one-clock pulse when data takes a new sample
//   period_start one-clock pulse on the first sample of each period
module wave_gen #(
  parameter int DATA_W  = 16,
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [1:0]         mode,
  input  logic [DATA_W-1:0]  amplitude,
  input  logic [PRESC_W-1:0] prescaler,
  output logic [DATA_W-1:0]  data,
  output logic               data_valid,
  output logic               period_start
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef enum logic [1:0] {
    SAW_UP = 2'd0,
    SAW_DN = 2'd1,
    TRI    = 2'd2,
    SQR    = 2'd3
  } mode_t;

  state_t             state;
  mode_t              mode_s;
  logic [DATA_W-1:0]  amp_s;
  logic [PRESC_W-1:0] presc_s;
  logic [PRESC_W-1:0] pcnt;
  logic [DATA_W:0]    ph;
  logic               up;

  logic               step;
  logic               wrap;
  logic [DATA_W-1:0]  nxt_data;
  logic [DATA_W:0]    nxt_ph;
  logic               nxt_up;
  logic [DATA_W-1:0]  start_data;

  // Start and wrap both take the live inputs, so the first sample of a period
  // is derived from the incoming configuration, not the shadowed one.
  assign start_data = (mode_t'(mode) == SAW_DN) ? amplitude : '0;
  assign step       = (pcnt == presc_s);

  // Next waveform value for a non-wrap step, and whether this step wraps.
  // Wrap is detected before any increment/decrement, so data never leaves
  // 0..amp_s and no counter is ever pushed past its terminal value.
  always_comb begin
    wrap     = 1'b0;
    nxt_data = data;
    nxt_ph   = ph;
    nxt_up   = up;
    case (mode_s)
      SAW_UP: begin
        if (data == amp_s) wrap = 1'b1;
        else               nxt_data = data + DATA_W'(1);
      end
      SAW_DN: begin
        if (data == '0) wrap = 1'b1;
        else            nxt_data = data - DATA_W'(1);
      end
      TRI: begin
        if (up) begin
          if (data == amp_s) begin
            // With A<=1 there is no descending leg: reaching A ends the period.
            if (amp_s <= DATA_W'(1)) begin
              wrap = 1'b1;
            end else begin
              nxt_up   = 1'b0;
              nxt_data = amp_s - DATA_W'(1);
            end
          end else begin
            nxt_data = data + DATA_W'(1);
          end
        end else begin
          if (data == DATA_W'(1)) wrap = 1'b1;
          else                    nxt_data = data - DATA_W'(1);
        end
      end
      SQR: begin
        // Terminal phase is 2A+1, formed by a shift so it cannot overflow.
        if (ph == {amp_s, 1'b1}) begin
          wrap = 1'b1;
        end else begin
          nxt_ph   = ph + (DATA_W+1)'(1);
          nxt_data = (nxt_ph <= {1'b0, amp_s}) ? '0 : amp_s;
        end
      end
      default: wrap = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mode_s       <= SAW_UP;
      amp_s        <= '0;
      presc_s      <= '0;
      pcnt         <= '0;
      ph           <= '0;
      up           <= 1'b1;
      data         <= '0;
      data_valid   <= 1'b0;
      period_start <= 1'b0;
    end else if (!ena) begin
      state        <= IDLE;
      pcnt         <= '0;
      ph           <= '0;
      up           <= 1'b1;
      data         <= '0;
      data_valid   <= 1'b0;
      period_start <= 1'b0;
    end else if (state == IDLE) begin
      state        <= RUN;
      mode_s       <= mode_t'(mode);
      amp_s        <= amplitude;
      presc_s      <= prescaler;
      pcnt         <= '0;
      ph           <= '0;
      up           <= 1'b1;
      data         <= start_data;
      data_valid   <= 1'b1;
      period_start <= 1'b1;
    end else if (step) begin
      pcnt       <= '0;
      data_valid <= 1'b1;
      if (wrap) begin
        mode_s       <= mode_t'(mode);
        amp_s        <= amplitude;
        presc_s      <= prescaler;
        ph           <= '0;
        up           <= 1'b1;
        data         <= start_data;
        period_start <= 1'b1;
      end else begin
        ph           <= nxt_ph;
        up           <= nxt_up;
        data         <= nxt_data;
        period_start <= 1'b0;
      end
    end else begin
      pcnt         <= pcnt + PRESC_W'(1);
      data_valid   <= 1'b0;
      period_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wave_gen.sv
// tb_wave_gen: self-checking bench for wave_gen. A behavioural model that
// indexes samples by position within the period is compared against the DUT
// on every falling edge; directed sequences add hand-computed expectations.
module tb_wave_gen;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [1:0]  mode;
  logic [15:0] amplitude;
  logic [15:0] prescaler;
  logic [15:0] data;
  logic        data_valid;
  logic        period_start;

  int n_assert = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  wave_gen #(.DATA_W(16), .PRESC_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .mode         (mode),
    .amplitude    (amplitude),
    .prescaler    (prescaler),
    .data         (data),
    .data_valid   (data_valid),
    .period_start (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input longint act, input longint exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  function automatic longint period_len(input int md, input longint a);
    case (md)
      0, 1:    return a + 1;
      2:       return (a == 0) ? 1 : 2 * a;
      default: return 2 * a + 2;
    endcase
  endfunction

  function automatic longint sample_at(input int md, input longint a, input longint n);
    case (md)
      0:       return n;
      1:       return a - n;
      2:       return (n <= a) ? n : 2 * a - n;
      default: return (n <= a) ? 0 : a;
    endcase
  endfunction

  bit     m_run;
  int     m_mode;
  longint m_amp, m_presc, m_pcnt, m_n;
  longint m_data;
  bit     m_dv, m_ps;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_mode = 0; m_amp = 0; m_presc = 0; m_pcnt = 0; m_n = 0;
      m_data = 0; m_dv = 0; m_ps = 0;
    end else if (!ena) begin
      m_run = 0; m_pcnt = 0; m_n = 0; m_data = 0; m_dv = 0; m_ps = 0;
    end else if (!m_run) begin
      m_run = 1; m_mode = int'(mode); m_amp = amplitude; m_presc = prescaler;
      m_pcnt = 0; m_n = 0;
      m_data = sample_at(m_mode, m_amp, 0); m_dv = 1; m_ps = 1;
    end else if (m_pcnt == m_presc) begin
      m_pcnt = 0; m_dv = 1; m_ps = 0;
      m_n++;
      if (m_n == period_len(m_mode, m_amp)) begin
        m_mode = int'(mode); m_amp = amplitude; m_presc = prescaler;
        m_n = 0; m_ps = 1;
      end
      m_data = sample_at(m_mode, m_amp, m_n);
    end else begin
      m_pcnt++; m_dv = 0; m_ps = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_data",   longint'(data),         m_data);
      chk("model_valid",  longint'(data_valid),   longint'(m_dv));
      chk("model_pstart", longint'(period_start), longint'(m_ps));
      if (m_run) begin
        n_assert++;
        if (data > m_amp) begin
          n_fail++;
          $display("FAIL data_range: got %0d, expected <= %0d", data, m_amp);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  longint q_d[$];
  bit     q_p[$];

  // Collect q_d.size() strobed samples and compare with the hand-computed
  // tables; spacing (>0) is the required number of clocks between strobes.
  task automatic expect_seq(input string nm, input int spacing);
    int got = 0;
    int cyc = 0;
    int last = 0;
    while (got < q_d.size() && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (data_valid) begin
        chk({nm, "_data"},   longint'(data),         q_d[got]);
        chk({nm, "_pstart"}, longint'(period_start), longint'(q_p[got]));
        if (got > 0 && spacing > 0) chk({nm, "_spacing"}, cyc - last, spacing);
        last = cyc;
        got++;
      end
    end
    if (got < q_d.size()) chk({nm, "_timeout"}, got, q_d.size());
  endtask

  task automatic wait_val(input string nm, input longint v);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(data_valid && data == v) && cyc < 500);
    if (cyc >= 500) chk({nm, "_wait_timeout"}, data, v);
  endtask

  task automatic stop_run();
    ena = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; mode = 2'd0; amplitude = '0; prescaler = '0;
    @(posedge clk);
    #1 cmp_en = 1;
    repeat (2) @(negedge clk);
    chk("reset_data",   data,         0);
    chk("reset_valid",  data_valid,   0);
    chk("reset_pstart", period_start, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // saw up, A=3, P=1
    mode = 2'd0; amplitude = 16'd3; prescaler = 16'd1; ena = 1'b1;
    q_d = '{0, 1, 2, 3, 0, 1}; q_p = '{1, 0, 0, 0, 1, 0};
    expect_seq("saw_up", 2);
    stop_run();

    // saw down, A=2, P=0
    mode = 2'd1; amplitude = 16'd2; prescaler = 16'd0; ena = 1'b1;
    q_d = '{2, 1, 0, 2, 1, 0}; q_p = '{1, 0, 0, 1, 0, 0};
    expect_seq("saw_dn", 1);
    stop_run();

    // triangle, A=3, P=0
    mode = 2'd2; amplitude = 16'd3; prescaler = 16'd0; ena = 1'b1;
    q_d = '{0, 1, 2, 3, 2, 1, 0, 1}; q_p = '{1, 0, 0, 0, 0, 0, 1, 0};
    expect_seq("tri3", 1);
    stop_run();

    // triangle, A=0: constant 0, wrap every step
    mode = 2'd2; amplitude = 16'd0; prescaler = 16'd0; ena = 1'b1;
    q_d = '{0, 0, 0, 0}; q_p = '{1, 1, 1, 1};
    expect_seq("tri0", 1);
    stop_run();

    // square, A=5, P=2: 36 clocks per period
    mode = 2'd3; amplitude = 16'd5; prescaler = 16'd2; ena = 1'b1;
    q_d = '{0, 0, 0, 0, 0, 0, 5, 5, 5, 5, 5, 5, 0};
    q_p = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    expect_seq("sqr5", 3);
    stop_run();

    // mid-period config change: saw up A=7 -> square A=1 at wrap
    mode = 2'd0; amplitude = 16'd7; prescaler = 16'd0; ena = 1'b1;
    wait_val("midchg", 2);
    mode = 2'd3; amplitude = 16'd1;
    q_d = '{3, 4, 5, 6, 7, 0, 0, 1, 1, 0};
    q_p = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
    expect_seq("midchg", 1);
    stop_run();

    // full-scale amplitude, saw down
    mode = 2'd1; amplitude = 16'hFFFF; prescaler = 16'd0; ena = 1'b1;
    q_d = '{65535, 65534, 65533}; q_p = '{1, 0, 0};
    expect_seq("fullscale", 1);
    stop_run();

    // asynchronous reset mid-triangle at data=4, release with ena high
    mode = 2'd2; amplitude = 16'd6; prescaler = 16'd1; ena = 1'b1;
    wait_val("rst_mid", 4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data",   data,         0);
    chk("async_rst_valid",  data_valid,   0);
    chk("async_rst_pstart", period_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    q_d = '{0, 1}; q_p = '{1, 0};
    expect_seq("rst_restart", 2);
    stop_run();

    // ena dropped for one clock exactly on a step edge
    mode = 2'd0; amplitude = 16'd4; prescaler = 16'd2; ena = 1'b1;
    wait_val("ena_drop", 2);
    repeat (2) @(negedge clk);
    ena = 1'b0; mode = 2'd1;
    @(negedge clk);
    chk("ena_drop_data",   data,         0);
    chk("ena_drop_valid",  data_valid,   0);
    chk("ena_drop_pstart", period_start, 0);
    ena = 1'b1;
    q_d = '{4, 3}; q_p = '{1, 0};
    expect_seq("ena_restart", 3);
    stop_run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wave_gen.md
# wave_gen

Parametrised multi-mode waveform generator: the successor to the single-mode sawtooth source in the signal-generation path. Produces sawtooth-up, sawtooth-down, triangle or square samples of programmable amplitude. The step rate is set by a clock prescaler. Configuration is shadowed and applied only at period boundaries, so mid-period writes never produce a glitch or an out-of-range sample. Samples feed the DAC/output formatter, with per-step and per-period strobes.

## Interface
- DATA_W, 16, sample and amplitude width
- PRESC_W, 16, prescaler width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  run enable; low = idle/cleared
- mode  in  2  0 saw up, 1 saw down, 2 triangle, 3 square
- amplitude  in  DATA_W  peak value A (unsigned)
- prescaler  in  PRESC_W  P; one step every P+1 clocks
- data  out  DATA_W  current sample
- data_valid  out  1  one-clock pulse when data takes a new sample
- period_start  out  1  one-clock pulse coincident with first sample of each period

## Operation
- Shadow registers mode_s, amp_s and presc_s hold the active configuration. They load from the inputs only at a start event and at each period wrap step.
- A start event is the first clock with ena sampled high while the block is idle.
- Live input changes mid-period have no effect until the next wrap step.
- Prescaler counter pcnt counts 0..presc_s. At pcnt == presc_s it returns to 0 and asserts the internal step signal.
- Start event:
  - shadows load
  - pcnt = 0
  - data = start value: A for saw down, 0 for all other modes
  - data_valid = 1 and period_start = 1
- Each step advances the waveform; wrap steps reload the shadows, and the emitted sample is the start value under the new config.
- Saw up: 0,1,…,A, then wrap to 0. Period = A+1 steps.
- Saw down: A,A-1,…,0, then wrap to A. Period = A+1 steps.
- Triangle:
  - sequence 0,1,…,A,A-1,…,1, then wrap to 0
  - direction register, up at start
  - turns at A and at 1
  - period 2A steps; A=0 gives constant 0 and a wrap every step
- Square:
  - phase counter ph (DATA_W+1 bits) counts 0..2A+1
  - data = 0 for ph ≤ A, else A
  - period 2(A+1) steps
  - A=0 gives constant 0 and a wrap every 2 steps
- All arithmetic is unsigned.
  - No sample ever exceeds amp_s.
  - A = 2^DATA_W−1 is legal; counters must not overflow.
- ena low (sampled):
  - on the next edge data = 0, pcnt = 0, ph = 0, direction = up
  - strobes = 0; block returns to idle
  - a later ena high is a fresh start event
- Reset (rst_n low, asynchronous, any time including mid-period):
  - data = 0, data_valid = 0, period_start = 0
  - pcnt = 0, ph = 0, direction = up
  - shadows = 0; block idle
  - after release, behaviour is identical to a first start event when ena is high

## Timing
- All outputs are registered.
- Start latency: ena sampled high at edge k gives the start sample, data_valid and period_start at edge k.
- Steps: subsequent samples at edges k+(P+1), k+2(P+1), …; data_valid is high for exactly one clock at each.
- P=0: a step every clock, data_valid held high continuously while running.
- period_start is high only on start and wrap samples, and always coincides with data_valid.
- A config write at any cycle takes effect on the first wrap step after it. This includes prescaler: the new P governs spacing only after that wrap.
- Simultaneous input change and wrap step on the same edge: the wrap samples the new inputs.
- ena low on the same edge as a step: clear wins, and no strobe is emitted.

## Test plan
- Saw up, A=3, P=1, ena rises -> data 0,1,2,3,0,1 every 2 clocks; period_start on each 0; data_valid one clock per step.
- Saw down, A=2, P=0 -> data 2,1,0,2,1,0 on consecutive clocks; data_valid constantly high; period_start on each 2.
- Triangle, A=3, P=0 -> data 0,1,2,3,2,1,0,1; period_start at cycles 0 and 6; A=0 -> constant 0 with period_start every clock.
- Square, A=5, P=2 -> six steps of 0, then six steps of 5, repeating; period_start every 36 clocks.
- Mid-period change: saw up A=7 running, at data=2 write A=1, mode=square -> saw continues 3…7, then wrap emits 0 and square with A=1 begins (0,0,1,1); data never exceeds the active A.
- Reset and ena: assert rst_n low mid-triangle at data=4 -> data=0 and strobes=0 immediately (asynchronous); release with ena high -> start sample 0 with period_start. Separately, drop ena for one clock at a step edge -> data=0 with no strobe, then restart from the start value.
